// File: rtl/uart_pkg.sv
// uart_pkg: parity modes and transmitter state encoding shared by the UART blocks
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_ODD = 1;
   localparam int PAR_EVEN = 2;
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: loadable bit-period down-counter, tick marks the last cycle of a bit
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [DIV_W-1:0] val,
   output logic             tick
);
   logic [DIV_W-1:0] cnt;
   always_ff @(posedge clk)
      if (rst) cnt <= '0;
      else if (load) cnt <= val - DIV_W'(1);
      else if (cnt != '0) cnt <= cnt - DIV_W'(1);
   assign tick = cnt == '0;
endmodule

// File: rtl/uart_tx_p.sv
// uart_tx_p: parametrised UART transmitter with built-in baud divider
module uart_tx_p
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int PARITY = 0,
   parameter int STOP_BITS = 1,
   parameter int DIV_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     div,
   input  logic                 data_rdy,
   input  logic [DATA_BITS-1:0] data,
   output logic                 out,
   output logic                 fetch,
   output logic                 busy
);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_D = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_S = IW'(STOP_BITS - 1);
   if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad
      $error("uart_tx_p: illegal DATA_BITS/PARITY/STOP_BITS");
   end
   tx_state_t state, state_d;
   logic [DATA_BITS-1:0] sh, sh_d;
   logic [IW-1:0] idx, idx_d;
   logic [DIV_W-1:0] dv, bit_div;
   logic par, par_d, tick, latch, load, out_d;
   uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
      .clk(clk),
      .rst(rst),
      .load(load),
      .val(bit_div),
      .tick(tick)
   );
   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else state <= state_d;
   // idx counts data bits in DATA and stop bits in STOP; it clears on every state change
   always_comb begin
      state_d = state;
      latch = 1'b0;
      case (state)
         IDLE: begin
            latch = data_rdy;
            state_d = data_rdy ? START : IDLE;
         end
         START: state_d = tick ? DATA : START;
         DATA: state_d = (tick && idx == LAST_D) ? ((PARITY != PAR_NONE) ? PAR : STOP) : DATA;
         PAR: state_d = tick ? STOP : PAR;
         STOP: if (tick && idx == LAST_S) begin
            latch = data_rdy;
            state_d = data_rdy ? START : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      load = latch || (tick && state != IDLE);
      bit_div = latch ? ((div == '0) ? DIV_W'(1) : div) : dv;
      sh_d = latch ? data : (state == DATA && tick) ? sh >> 1 : sh;
      par_d = latch ? ((PARITY == PAR_ODD) ? ~^data : ^data) : par;
      idx_d = (state_d != state) ? '0 : (tick && state != IDLE) ? idx + 1'b1 : idx;
   end
   always_comb
      out_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : (state_d == PAR) ? par_d : 1'b1;
   always_ff @(posedge clk)
      if (rst) begin
         sh <= '0;
         par <= 1'b0;
         idx <= '0;
         dv <= '0;
         out <= 1'b1;
         fetch <= 1'b0;
         busy <= 1'b0;
      end else begin
         sh <= sh_d;
         par <= par_d;
         idx <= idx_d;
         dv <= bit_div;
         out <= out_d;
         fetch <= latch;
         busy <= state_d != IDLE;
      end
endmodule
